instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder side of the instruction-fetch interface. The PC/adder fetch logic drives an address and a request; this block returns the addressed program word.
- Owns program memory and a load port. The load port accepts the program image word by word from the host/bootloader before execution.
- Sits between the fetch control block and the decode stage.

Parameters:
- addrLength, 11, width of fetch/load address; memory depth = 2**addrLength words
- dataLength, 16, instruction word width
- haltOpcode, 5'b00000, opcode (word bits [dataLength-1 : dataLength-5]) that terminates a load

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request from the PC side, sampled on clk
- fetch_addr  in  addrLength  word address to fetch (the program count)
- fetch_ready  out  1  high when requests are accepted (RUN state only)
- instr  out  dataLength  returned instruction word
- instr_valid  out  1  one-cycle strobe: instr holds a response
- load_start  in  1  begin (re)loading the program image
- load_wr  in  1  write strobe for load_data
- load_data  in  dataLength  program word to store
- load_done  out  1  one-cycle pulse when the load completes
- load_count  out  addrLength+1  number of words loaded

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, write pointer=0, load_count=0
  - fetch_ready=0, instr=0, instr_valid=0, load_done=0
  - Memory contents are not cleared; they are unreachable because load_count=0.
- States: IDLE, LOAD, RUN (2-bit encoding).
- IDLE:
  - fetch_ready=0; fetch_req and load_wr are ignored.
  - load_start=1 -> LOAD next cycle, write pointer <= 0, load_count <= 0.
- LOAD:
  - fetch_ready=0; fetch_req is ignored.
  - Each cycle with load_wr=1: mem[wptr] <= load_data, wptr++, load_count++.
  - Termination: a written word whose top 5 bits equal haltOpcode, or a write at wptr = 2**addrLength-1.
  - On termination the word is still stored and counted. Next cycle: state=RUN and load_done=1 for exactly one cycle.
  - load_start during LOAD restarts the load (wptr=0, count=0). It takes priority over a simultaneous load_wr, and that word is discarded.
- RUN:
  - fetch_ready=1.
  - fetch_req=1 at edge N -> at edge N+1, instr=mem[fetch_addr] and instr_valid=1. Fixed 1-cycle latency; back-to-back requests give back-to-back responses.
  - Out-of-range address (fetch_addr >= load_count): instr = 0 (HALT word), instr_valid=1.
  - No request -> instr_valid=0 and instr holds its last value.
  - load_start=1 -> LOAD next cycle. A simultaneous fetch_req is dropped (no instr_valid). A response already due at that edge is still delivered.
- load_wr outside LOAD has no effect.
- Memory is synchronous-read, single write port, one read port. Reads and writes never overlap in time because of the state gating.
- Counter widths: load_count is addrLength+1 bits so that a full memory (2048) is representable. wptr does not wrap; termination on the last address guarantees this.

Decomposition:
- Shared package (imem_pkg):
  - state encodings IDLE/LOAD/RUN
  - HALT_OPCODE constant
  - default ADDR_LEN=11, DATA_LEN=16
- One sub-module: prog_ram, a parameterised 1W/1R synchronous RAM (we, waddr, wdata, re, raddr, rdata).
- instr_mem_responder holds the FSM, write pointer, count, range check and response register.

Test Plan:
1. Reset then idle: reset low for 3 cycles, release, fetch_req=1 addr 0 -> fetch_ready=0, instr_valid never asserts, instr=0.
2. Load and fetch: load_start, write 16'h0801, 16'h1002, 16'h0000 (halt) -> load_done pulse one cycle after the halt write, load_count=3. Then fetch addr 1 -> instr=16'h1002 with instr_valid one cycle later.
3. Streaming fetch: in RUN, fetch_req held high with addr 0,1,2 on successive cycles -> instr 16'h0801, 16'h1002, 16'h0000 on the following three cycles, instr_valid continuously high.
4. Out of range: after scenario 2, fetch addr 5 -> instr=16'h0000, instr_valid=1.
5. Reload collision: in RUN, assert load_start and fetch_req together -> no instr_valid for that request, state=LOAD, load_count=0. Reload 16'hA5A5, 16'h0000 -> fetch addr 0 returns 16'hA5A5.
6. Reset mid-load and full load:
   - Assert reset after 2 writes -> IDLE, load_count=0, no load_done.
   - Separately, load 2048 non-halt words -> load_done after the 2048th write, load_count=2048, fetch addr 2047 returns the last word.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   state_t     : controller states (IDLE / LOAD / RUN), 2-bit encoding
//   ADDR_LEN    : default fetch/load address width
//   DATA_LEN    : default instruction word width
//   HALT_OPCODE : opcode in the top five word bits that ends a program load
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned ADDR_LEN    = 11;
    localparam int unsigned DATA_LEN    = 16;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch + load bus between the fetch/host side (master) and the responder (slave).
//   fetch_req/fetch_addr      : fetch request and word address
//   fetch_ready               : responder accepts fetches
//   instr/instr_valid         : returned word and its one-cycle strobe
//   load_start/load_wr/load_data : program image load port
//   load_done/load_count      : load completion pulse and loaded word count
interface instr_mem_responder_if #(
    parameter int unsigned ADDR_LEN = 11,
    parameter int unsigned DATA_LEN = 16
);
    logic                fetch_req;
    logic [ADDR_LEN-1:0] fetch_addr;
    logic                fetch_ready;
    logic [DATA_LEN-1:0] instr;
    logic                instr_valid;
    logic                load_start;
    logic                load_wr;
    logic [DATA_LEN-1:0] load_data;
    logic                load_done;
    logic [ADDR_LEN:0]   load_count;

    modport master (
        output fetch_req, fetch_addr, load_start, load_wr, load_data,
        input  fetch_ready, instr, instr_valid, load_done, load_count
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_wr, load_data,
        output fetch_ready, instr, instr_valid, load_done, load_count
    );
endinterface

// File: rtl/prog_ram.sv
// Program memory: one synchronous write port, one synchronous read port.
//   we/waddr/wdata : write strobe, address, data
//   re/raddr/rdata : read enable, address, registered read data (held when re=0)
// Contents are deliberately not reset.
module prog_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: loads a program image, then serves fetches.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fetch/load interface (slave side)
// Fetches return one cycle after acceptance; addresses at or beyond
// load_count return the all-zero HALT word.
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int unsigned addrLength = ADDR_LEN,
    parameter int unsigned dataLength = DATA_LEN,
    parameter logic [4:0]  haltOpcode = HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_mem_responder_if.slave  bus
);
    localparam logic [addrLength-1:0] LAST_ADDR = '1;

    state_t                state, state_next;
    logic [addrLength-1:0] wptr;
    logic [addrLength:0]   count;
    logic                  we, re, accept, term, restart;
    logic                  in_range_q, valid_q, done_q;
    logic [dataLength-1:0] rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        re         = 1'b0;
        accept     = 1'b0;
        term       = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // a restart wins over a simultaneous write, discarding that word
                if (bus.load_start) begin
                    restart = 1'b1;
                end else if (bus.load_wr) begin
                    we   = 1'b1;
                    term = (bus.load_data[dataLength-1 -: 5] == haltOpcode) ||
                           (wptr == LAST_ADDR);
                    if (term) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end else if (bus.fetch_req) begin
                    accept = 1'b1;
                    re     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            count      <= '0;
            in_range_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= accept;
            done_q  <= term;
            if (restart) begin
                wptr  <= '0;
                count <= '0;
            end else if (we) begin
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end
            // range flag only moves with an accepted fetch, so instr holds otherwise
            if (accept) begin
                in_range_q <= ({1'b0, bus.fetch_addr} < count);
            end
        end
    end

    prog_ram #(
        .ADDR_W (addrLength),
        .DATA_W (dataLength)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (bus.load_data),
        .re    (re),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    assign bus.fetch_ready = (state == RUN);
    assign bus.instr       = in_range_q ? rdata : '0;
    assign bus.instr_valid = valid_q;
    assign bus.load_done   = done_q;
    assign bus.load_count  = count;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed sequences, a vector
// table and randomized fetch/reload traffic against a queue-based model.
module tb_instr_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_mem_responder_if #(.ADDR_LEN(11), .DATA_LEN(16)) bus ();

    instr_mem_responder #(
        .addrLength (11),
        .dataLength (16),
        .haltOpcode (5'b00000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model: loaded program as a queue, plus expected outputs
    logic [15:0] prog [$];
    logic [15:0] exp_instr = '0;

    typedef struct {
        logic        req;
        logic [10:0] addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [10:0] a);
        return (int'(a) < prog.size()) ? prog[a] : 16'h0000;
    endfunction

    task automatic fetch(input logic req, input logic [10:0] a, input string name);
        bus.fetch_req  = req;
        bus.fetch_addr = a;
        step();
        if (req) exp_instr = model_read(a);
        chk({name, "_valid"}, bus.instr_valid, req);
        chk({name, "_instr"}, bus.instr, exp_instr);
        bus.fetch_req = 1'b0;
    endtask

    task automatic load_image(input logic [15:0] words [$], input string name);
        bit term;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk({name, "_cnt0"}, bus.load_count, 0);
        chk({name, "_ready0"}, bus.fetch_ready, 0);
        prog.delete();
        foreach (words[i]) begin
            bus.load_wr   = 1'b1;
            bus.load_data = words[i];
            step();
            prog.push_back(words[i]);
            term = (words[i][15:11] == 5'b00000) || (prog.size() == 2048);
            if (term || i == words.size() - 1) begin
                chk({name, "_done"}, bus.load_done, term);
                chk({name, "_ready"}, bus.fetch_ready, term);
            end else if (bus.load_done !== 1'b0) begin
                chk({name, "_early_done"}, bus.load_done, 0);
            end
            if (term) break;
        end
        bus.load_wr = 1'b0;
        step();
        chk({name, "_done_pulse"}, bus.load_done, 0);
        chk({name, "_count"}, bus.load_count, prog.size());
    endtask

    initial begin
        logic [15:0] img [$];
        logic [15:0] w;
        int unsigned n;

        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_wr    = 1'b0;
        bus.load_data  = '0;

        // 1. reset then idle
        repeat (3) step();
        chk("rst_ready", bus.fetch_ready, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_done", bus.load_done, 0);
        chk("rst_count", bus.load_count, 0);
        reset = 1'b1;
        bus.fetch_req = 1'b1;
        bus.load_wr   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_valid", bus.instr_valid, 0);
            chk("idle_ready", bus.fetch_ready, 0);
            chk("idle_instr", bus.instr, 0);
        end
        bus.fetch_req = 1'b0;
        bus.load_wr   = 1'b0;
        chk("idle_count", bus.load_count, 0);

        // 2. load and fetch
        img = '{16'h0801, 16'h1002, 16'h0000};
        load_image(img, "load3");
        chk("load3_cnt3", bus.load_count, 3);
        fetch(1'b1, 11'd1, "f1");
        chk("f1_const", bus.instr, 16'h1002);

        // 3/4. streaming, hold and out-of-range via vector table
        tbl[0]  = '{1'b1, 11'd0,    1'b1, 16'h0801};
        tbl[1]  = '{1'b1, 11'd1,    1'b1, 16'h1002};
        tbl[2]  = '{1'b1, 11'd2,    1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 11'd0,    1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 11'd0,    1'b1, 16'h0801};
        tbl[5]  = '{1'b0, 11'd3,    1'b0, 16'h0801};
        tbl[6]  = '{1'b1, 11'd5,    1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 11'd1,    1'b1, 16'h1002};
        tbl[8]  = '{1'b1, 11'd3,    1'b1, 16'h0000};
        tbl[9]  = '{1'b1, 11'd1,    1'b1, 16'h1002};
        tbl[10] = '{1'b1, 11'd2047, 1'b1, 16'h0000};
        tbl[11] = '{1'b0, 11'd1,    1'b0, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            bus.fetch_req  = tbl[i].req;
            bus.fetch_addr = tbl[i].addr;
            step();
            chk($sformatf("tbl%0d_valid", i), bus.instr_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].exp_instr);
            exp_instr = tbl[i].exp_instr;
        end
        bus.fetch_req = 1'b0;

        // load_wr in RUN has no effect
        bus.load_wr   = 1'b1;
        bus.load_data = 16'h0000;
        step();
        bus.load_wr = 1'b0;
        chk("runwr_done", bus.load_done, 0);
        chk("runwr_count", bus.load_count, 3);
        fetch(1'b1, 11'd0, "runwr_f0");

        // 5. reload collision
        fetch(1'b1, 11'd1, "pre_coll");
        bus.load_start = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 11'd0;
        step();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        chk("coll_valid", bus.instr_valid, 0);
        chk("coll_ready", bus.fetch_ready, 0);
        chk("coll_count", bus.load_count, 0);
        prog.delete();
        img = '{16'hA5A5, 16'h0000};
        foreach (img[i]) begin
            bus.load_wr   = 1'b1;
            bus.load_data = img[i];
            step();
            prog.push_back(img[i]);
        end
        bus.load_wr = 1'b0;
        chk("coll_done", bus.load_done, 1);
        step();
        chk("coll_count2", bus.load_count, 2);
        fetch(1'b1, 11'd0, "coll_f0");
        chk("coll_f0_const", bus.instr, 16'hA5A5);

        // restart during LOAD discards the simultaneous word
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_wr = 1'b1; bus.load_data = 16'h1111; step();
        bus.load_start = 1'b1; bus.load_data = 16'h2222; step();
        bus.load_start = 1'b0;
        chk("rst_in_load_cnt", bus.load_count, 0);
        bus.load_data = 16'h3333; step();
        bus.load_data = 16'h0000; step();
        bus.load_wr = 1'b0;
        chk("rst_in_load_done", bus.load_done, 1);
        prog.delete();
        prog.push_back(16'h3333);
        prog.push_back(16'h0000);
        step();
        chk("rst_in_load_cnt2", bus.load_count, 2);
        fetch(1'b1, 11'd0, "rst_in_load_f0");
        fetch(1'b1, 11'd1, "rst_in_load_f1");

        // 6a. asynchronous reset mid-load
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_wr = 1'b1; bus.load_data = 16'h4444; step();
        bus.load_data = 16'h5555; step();
        chk("midload_cnt2", bus.load_count, 2);
        reset = 1'b0;
        #1;
        chk("midload_async_cnt", bus.load_count, 0);
        chk("midload_async_instr", bus.instr, 0);
        step();
        bus.load_wr = 1'b0;
        reset = 1'b1;
        prog.delete();
        exp_instr = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midload_done", bus.load_done, 0);
            chk("midload_ready", bus.fetch_ready, 0);
            chk("midload_cnt", bus.load_count, 0);
        end

        // 6b. full 2048-word load with no halt word
        img.delete();
        for (int i = 0; i < 2048; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) w[15] = 1'b1;
            img.push_back(w);
        end
        load_image(img, "full");
        chk("full_count", bus.load_count, 2048);
        fetch(1'b1, 11'd2047, "full_last");
        chk("full_last_word", bus.instr, img[2047]);
        fetch(1'b1, 11'd0, "full_first");

        // randomized fetch traffic and random reloads against the model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 150; i++) begin
                n = $urandom_range(0, prog.size() + 4);
                if (n > 2047) n = 2047;
                fetch(1'($urandom_range(0, 3) != 0), 11'(n), $sformatf("rnd%0d", r));
            end
            img.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < int'(n); i++) begin
                w = 16'($urandom);
                if (i == int'(n) - 1) w[15:11] = 5'b00000;
                else if (w[15:11] == 5'b00000) w[12] = 1'b1;
                img.push_back(w);
            end
            load_image(img, $sformatf("rndload%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
